// File: rtl/dly_ld_sequencer_pkg.sv
// Shared constants and state encoding for the delay-load sequencer.
// The helper turns a cycle count into the matching down-counter load value.
package dly_seq_pkg;

   localparam int DLY_W = 8;

   localparam logic DIR_ODELAY = 1'b0;
   localparam logic DIR_IDELAY = 1'b1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SET    = 3'd1,
      GAP    = 3'd2,
      APPLY  = 3'd3,
      SETTLE = 3'd4
   } state_t;

   // The counter hits zero in the last cycle of a timed state, so it loads count-1.
   function automatic logic [3:0] cnt_load(input int cycles);
      logic [3:0] val;
      val = '0;
      if (cycles > 1) begin
         val = 4'(cycles - 1);
      end
      return val;
   endfunction

endpackage

// File: rtl/dly_ld_sequencer_if.sv
// Request channel into the sequencer: valid/ready handshake plus the command fields.
// The master drives commands; the sequencer owns req_ready.
interface dly_ld_sequencer_if
   import dly_seq_pkg::*;
#(
   parameter int LANE_W = 4
) ();

   logic              req_valid;
   logic              req_ready;
   logic              req_apply;
   logic              req_dir;
   logic [LANE_W-1:0] req_lane;
   logic [DLY_W-1:0]  req_delay;

   modport master (
      output req_valid,
      output req_apply,
      output req_dir,
      output req_lane,
      output req_delay,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_apply,
      input  req_dir,
      input  req_lane,
      input  req_delay,
      output req_ready
   );

endinterface

// File: rtl/dly_ld_sequencer.sv
// Sequences two-step (set, then ld) delay programming for a byte lane of I/O cells.
// Sets are issued one lane at a time; an apply pulses ld on every pending lane at once.
module dly_ld_sequencer
   import dly_seq_pkg::*;
#(
   parameter int NUM_LANES    = 9,
   parameter int LANE_W       = 4,
   parameter int SET_GAP      = 1,
   parameter int APPLY_SETTLE = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   dly_ld_sequencer_if.slave    req,
   output logic [DLY_W-1:0]     dly_data,
   output logic [NUM_LANES-1:0] set_odelay,
   output logic [NUM_LANES-1:0] set_idelay,
   output logic [NUM_LANES-1:0] ld_odelay,
   output logic [NUM_LANES-1:0] ld_idelay,
   output logic [NUM_LANES-1:0] pend_odelay,
   output logic [NUM_LANES-1:0] pend_idelay,
   output logic                 busy,
   output logic                 done,
   output logic                 err_lane
);

   localparam logic [LANE_W:0] LANE_LIM    = (LANE_W + 1)'(NUM_LANES);
   localparam logic [3:0]      GAP_LOAD    = cnt_load(SET_GAP);
   localparam logic [3:0]      SETTLE_LOAD = cnt_load(APPLY_SETTLE);

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [LANE_W-1:0]     lane_q, lane_d;
   logic                  dir_q, dir_d;
   logic [DLY_W-1:0]      dly_q, dly_d;
   logic [NUM_LANES-1:0]  set_o_q, set_o_d;
   logic [NUM_LANES-1:0]  set_i_q, set_i_d;
   logic [NUM_LANES-1:0]  ld_o_q, ld_o_d;
   logic [NUM_LANES-1:0]  ld_i_q, ld_i_d;
   logic [NUM_LANES-1:0]  pend_o_q, pend_o_d;
   logic [NUM_LANES-1:0]  pend_i_q, pend_i_d;
   logic                  ready_q, ready_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;

   logic [NUM_LANES-1:0]  req_hot;
   logic [NUM_LANES-1:0]  cap_hot;
   logic                  accept;
   logic                  lane_ok;

   // req_hot drives the set pulse; cap_hot marks the captured lane pending one cycle later.
   generate
      for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_hot
         assign req_hot[gi] = (req.req_lane == LANE_W'(gi));
         assign cap_hot[gi] = (lane_q == LANE_W'(gi));
      end
   endgenerate

   assign accept  = req.req_valid & ready_q;
   assign lane_ok = ({1'b0, req.req_lane} < LANE_LIM);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      lane_d   = lane_q;
      dir_d    = dir_q;
      dly_d    = dly_q;
      set_o_d  = '0;
      set_i_d  = '0;
      ld_o_d   = '0;
      ld_i_d   = '0;
      pend_o_d = pend_o_q;
      pend_i_d = pend_i_q;
      err_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (req.req_apply) begin
                  ld_o_d  = pend_o_q;
                  ld_i_d  = pend_i_q;
                  state_d = APPLY;
               end else if (lane_ok) begin
                  lane_d  = req.req_lane;
                  dir_d   = req.req_dir;
                  dly_d   = req.req_delay;
                  state_d = SET;
                  if (req.req_dir == DIR_IDELAY) begin
                     set_i_d = req_hot;
                  end else begin
                     set_o_d = req_hot;
                  end
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         SET: begin
            if (dir_q == DIR_IDELAY) begin
               pend_i_d = pend_i_q | cap_hot;
            end else begin
               pend_o_d = pend_o_q | cap_hot;
            end
            if (SET_GAP > 0) begin
               state_d = GAP;
               cnt_d   = GAP_LOAD;
            end else begin
               state_d = IDLE;
            end
         end

         GAP: begin
            if (cnt_q == 4'd0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end

         APPLY: begin
            pend_o_d = '0;
            pend_i_d = '0;
            state_d  = SETTLE;
            cnt_d    = SETTLE_LOAD;
         end

         SETTLE: begin
            if (cnt_q == 4'd0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Status flags are registered from the next state so they line up with it.
      ready_d = (state_d == IDLE);
      busy_d  = (state_d != IDLE);
      done_d  = (state_d == SETTLE) && (cnt_d == 4'd0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         lane_q   <= '0;
         dir_q    <= DIR_ODELAY;
         dly_q    <= '0;
         set_o_q  <= '0;
         set_i_q  <= '0;
         ld_o_q   <= '0;
         ld_i_q   <= '0;
         pend_o_q <= '0;
         pend_i_q <= '0;
         ready_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         lane_q   <= lane_d;
         dir_q    <= dir_d;
         dly_q    <= dly_d;
         set_o_q  <= set_o_d;
         set_i_q  <= set_i_d;
         ld_o_q   <= ld_o_d;
         ld_i_q   <= ld_i_d;
         pend_o_q <= pend_o_d;
         pend_i_q <= pend_i_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign req.req_ready = ready_q;
   assign dly_data      = dly_q;
   assign set_odelay    = set_o_q;
   assign set_idelay    = set_i_q;
   assign ld_odelay     = ld_o_q;
   assign ld_idelay     = ld_i_q;
   assign pend_odelay   = pend_o_q;
   assign pend_idelay   = pend_i_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign err_lane      = err_q;

endmodule

// File: doc/dly_ld_sequencer.md
Name: dly_ld_sequencer

Overview:
- Sequences delay programming for a byte lane of single-bit DQ/DM I/O cells.
- Each I/O cell has a 2-step idelay/odelay update: "set" latches the shared 8-bit delay bus into a lane shadow register, and "ld" applies the shadow value.
- The block accepts lane-targeted delay writes through a valid/ready handshake and drives the shared dly_data bus and per-lane set pulses.
- On an apply command it pulses ld for every pending lane in the same cycle, so all lanes switch together. It sits in the clk_div domain between the calibration/host logic and the PHY lanes.

Parameters:
- NUM_LANES, 9, number of I/O cells driven (8 DQ + DM).
- LANE_W, 4, width of lane index; must satisfy 2**LANE_W >= NUM_LANES.
- SET_GAP, 1, idle cycles after a set pulse with dly_data held stable (0..15).
- APPLY_SETTLE, 4, cycles after the ld pulse before done/ready (1..15).

Ports:
- clk  input  1  clk_div-domain clock (same clock as PHY delay control)
- rst_n  input  1  synchronous reset, active low
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_apply  input  1  1 = apply command (lane/dir/delay ignored), 0 = set command
- req_dir  input  1  0 = odelay, 1 = idelay
- req_lane  input  LANE_W  target lane index
- req_delay  input  8  delay value (3 LSB fine)
- dly_data  output  8  shared delay bus to all lanes
- set_odelay  output  NUM_LANES  per-lane one-cycle set pulse, odelay
- set_idelay  output  NUM_LANES  per-lane one-cycle set pulse, idelay
- ld_odelay  output  NUM_LANES  per-lane one-cycle apply pulse, odelay
- ld_idelay  output  NUM_LANES  per-lane one-cycle apply pulse, idelay
- pend_odelay  output  NUM_LANES  lanes set but not yet applied, odelay
- pend_idelay  output  NUM_LANES  lanes set but not yet applied, idelay
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse at end of apply settle
- err_lane  output  1  one-cycle pulse: set command with req_lane >= NUM_LANES

Behaviour:
- Single clock (clk); reset is synchronous and active-low (rst_n).
- All outputs are registered.
- Reset values:
  - all set/ld/pend vectors = 0
  - dly_data = 0
  - done = 0, err_lane = 0, busy = 0
  - req_ready = 0 while rst_n = 0 and 1 from the first cycle after release
  - state = IDLE
- Handshake:
  - A request is accepted on a clock edge with req_valid & req_ready.
  - req_ready = 1 only in IDLE (not reset).
  - No combinational path from req_* to req_ready.
- States: IDLE, SET, GAP, APPLY, SETTLE.
- IDLE:
  - Accepted set command with a legal lane → capture lane/dir, load dly_data <= req_delay, go to SET.
  - Accepted set command with lane >= NUM_LANES → err_lane = 1 next cycle, no set pulse, no pend change, dly_data unchanged, stay in IDLE. req_ready stays 1.
  - Accepted apply command → go to APPLY.
- SET (1 cycle):
  - Exactly one bit set: set_odelay[lane] if dir = 0, else set_idelay[lane].
  - The matching pend bit is set at the end of the cycle.
  - Next state is GAP if SET_GAP > 0, else IDLE.
- GAP (SET_GAP cycles): dly_data held, no pulses; then IDLE.
- Set latency: accept at edge T, set pulse high in cycle T+1, next accept possible at edge T+2+SET_GAP.
- Re-setting a lane that is already pending overwrites its shadow value; its pend bit stays 1.
- APPLY (1 cycle):
  - ld_odelay = pend_odelay and ld_idelay = pend_idelay, simultaneously.
  - Both pend vectors clear at the end of the cycle.
  - If both pend vectors are 0, no ld pulses are issued, but the sequence still runs to done.
- SETTLE (APPLY_SETTLE cycles): done pulses in the last cycle, then IDLE.
- Apply latency: accept at T, ld in cycle T+1, done in cycle T+1+APPLY_SETTLE, ready again in cycle T+2+APPLY_SETTLE.
- dly_data holds its last value in IDLE and is not modified by apply.
- Reset mid-operation (rst_n low in any state):
  - Next cycle everything is at reset values and pending lanes are lost.
  - Any in-flight set or ld pulse is truncated; no partial apply is issued.

Decomposition:
- Package dly_seq_pkg holds:
  - state encoding constants (IDLE, SET, GAP, APPLY, SETTLE)
  - DIR_ODELAY = 0, DIR_IDELAY = 1
  - DLY_W = 8
- The GAP and SETTLE states share one 4-bit down-counter inside the FSM.
- Lane one-hot decode is inline; no sub-module is needed.

Test Plan:
- Reset, then set lane 3, odelay, delay 0x5A (SET_GAP = 1):
  - dly_data = 0x5A, set_odelay = 9'h008 for exactly 1 cycle at T+1
  - pend_odelay = 9'h008
  - req_ready low in cycles T+1 and T+2, high again in cycle T+3
- Set lane 0 idelay 0x10, lane 8 odelay 0x33, lane 0 idelay 0x11, then apply:
  - ld_idelay = 9'h001 and ld_odelay = 9'h100 in the same single cycle
  - pend vectors = 0 afterwards
  - done asserted APPLY_SETTLE = 4 cycles after the ld cycle
  - dly_data = 0x11 after the sequence
- Apply with nothing pending: no ld pulses; done still asserted 5 cycles after accept.
- Set with lane = 9 (NUM_LANES = 9): err_lane pulses 1 cycle; set vectors, pend vectors and dly_data unchanged; req_ready stays 1.
- Back-to-back req_valid held high for 4 set commands: one set pulse per accepted request, accepts spaced 2+SET_GAP cycles, no request dropped.
- rst_n driven low during SETTLE after an apply, and separately during GAP with lanes pending: next cycle all outputs at reset values; done never pulses; pend vectors = 0.
